// File: rtl/arb_rr_4_pkg.sv
// Shared constants, state encoding and round-robin pick helper for the 4-way arbiter.
package arb_rr_4_pkg;

    localparam int unsigned N_DEFAULT = 32;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned IDX_W     = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First requester at or after ptr (wrapping) with its request bit set.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p    = '0;
        cand = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/arb_rr_4_if.sv
// Requester-side bundle of the round-robin arbiter: requests, data words, done and grant outputs.
interface arb_rr_4_if
    import arb_rr_4_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
);
    logic [NUM_REQ-1:0] req;
    logic [N-1:0]       A;
    logic [N-1:0]       B;
    logic [N-1:0]       C;
    logic [N-1:0]       D;
    logic               done;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   sel;
    logic [N-1:0]       Z;
    logic               busy;

    modport master (output req, A, B, C, D, done, input gnt, sel, Z, busy);
    modport slave  (input req, A, B, C, D, done, output gnt, sel, Z, busy);
endinterface

// File: rtl/arb_rr_4_mux.sv
// Parameterised 4:1 multiplexer, purely combinational.
module arb_rr_4_mux #(
    parameter int unsigned N = 32
) (
    input  logic [1:0]   sel,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    output logic [N-1:0] z
);
    always_comb begin
        z = d0;
        case (sel)
            2'd0: z = d0;
            2'd1: z = d1;
            2'd2: z = d2;
            2'd3: z = d3;
        endcase
    end
endmodule

// File: rtl/arb_rr_4.sv
// Four-requester round-robin arbiter with hold-until-release ownership and direct handoff.
module arb_rr_4
    import arb_rr_4_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    arb_rr_4_if.slave  bus
);
    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               busy_q, busy_d;

    pick_t              pick;
    logic               release_ev;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        busy_d     = busy_q;
        pick       = '0;
        release_ev = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pick = rr_pick(bus.req, ptr_q);
                if (pick.found) begin
                    state_d = ST_OWN;
                    gnt_d   = onehot(pick.idx);
                    sel_d   = pick.idx;
                    busy_d  = 1'b1;
                end
            end
            ST_OWN: begin
                // done and a dropped request together are a single release
                release_ev = bus.done | ~bus.req[sel_q];
                if (release_ev) begin
                    ptr_d = sel_q + IDX_W'(1);
                    pick  = rr_pick(bus.req & ~onehot(sel_q), ptr_d);
                    if (pick.found) begin
                        gnt_d = onehot(pick.idx);
                        sel_d = pick.idx;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;

    arb_rr_4_mux #(.N(N)) u_mux (
        .sel (sel_q),
        .d0  (bus.A),
        .d1  (bus.B),
        .d2  (bus.C),
        .d3  (bus.D),
        .z   (bus.Z)
    );
endmodule

// File: doc/arb_rr_4.md
ARB_RR_4 -- requirements
Module: arb_rr_4

Interface
REQ-001 Parameter N, default 32, width of each requester data word and of output Z.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 req  input  4  request vector; bit i high = requester i wants the shared resource.
REQ-005 A, B, C, D  input  N each  data words of requesters 0, 1, 2, 3.
REQ-006 done  input  1  shared resource signals the current owner's transaction is complete.
REQ-007 gnt  output  4  one-hot grant vector, registered; all zero when no owner.
REQ-008 sel  output  2  registered binary index of current or last owner.
REQ-009 Z  output  N  data of requester sel, i.e. A/B/C/D for sel 0/1/2/3; combinational from sel.
REQ-010 busy  output  1  registered; high while any gnt bit is high.

Function
REQ-011 FSM states: IDLE (no owner) and OWN (one requester holds the grant).
REQ-012 Priority pointer ptr (2 bits): search order ptr, ptr+1, ptr+2, ptr+3 mod 4; the first requester with req high in that order wins.
REQ-013 IDLE with req != 0 at an edge: next cycle state=OWN, gnt=onehot(winner), sel=winner, busy=1; grant latency is 1 cycle.
REQ-014 IDLE with req == 0: gnt, busy stay 0; sel holds its previous value.
REQ-015 OWN: gnt, sel stay fixed while done=0 and req[sel]=1; other requests are ignored (no preemption).
REQ-016 Release event = done=1, or req[sel]=0, in OWN; done and a dropped req in the same cycle count as one release.
REQ-017 On release: ptr <= sel+1 mod 4; the winner is chosen from current req with bit sel masked, using the new ptr.
REQ-018 Release with another request pending: direct handoff next cycle, with gnt and sel set to the new winner, busy staying 1, and no idle cycle.
REQ-019 Release with no other request pending (req[sel] alone or none): state=IDLE, gnt=0, busy=0 next cycle; the released requester re-arbitrates from IDLE at the following edge.
REQ-020 Fairness: with all four req held high and done pulsed each cycle, grants rotate 0,1,2,3,0,...; no requester waits more than 3 grants.
REQ-021 ptr advances only on release; it never changes in IDLE.
REQ-022 Z is a pure function of sel and A–D; it is valid whenever busy=1 and otherwise undefined for the consumer.
REQ-023 gnt is at most one-hot at all times; busy == |gnt at all times.

Reset
REQ-024 rst=1 at an edge forces state=IDLE, gnt=0, sel=0, busy=0, ptr=0 (requester 0 highest priority), overriding all other inputs.
REQ-025 Reset mid-ownership drops the grant in the same edge; no release-based ptr update occurs.
REQ-026 First arbitration after rst deasserts follows REQ-013 with ptr=0.

Structure
REQ-027 Shared package/header holds the state encodings IDLE/OWN, the default N=32, and the requester count constant 4.
REQ-028 The data path SHALL be one instance of the existing parameterised 4:1 multiplexer, with sel driving its select and N passed through; arbitration logic stays in arb_rr_4.

Verification
REQ-029 rst for 2 cycles, then req=4'b0000 -> gnt=0, sel=0, busy=0, Z=A.
REQ-030 A=4526, B=5659, C=745, D=2156; req=4'b0100 -> 1 cycle later gnt=4'b0100, sel=2, Z=745, busy=1; done pulse with req held -> IDLE next cycle, then regrant of 2 the cycle after.
REQ-031 req=4'b1111 held, done pulsed each cycle after first grant -> gnt sequence 0001, 0010, 0100, 1000, 0001 with busy constantly 1.
REQ-032 Owner 1 (sel=1) with req=4'b1011, done=0 for 5 cycles -> gnt stays 0010; then req[1] drops -> next gnt=1000 (ptr=2 skips to 3).
REQ-033 Owner 3 with done=1 and rst=1 in the same cycle -> gnt=0, sel=0, ptr=0; next req=4'b1001 -> grant to requester 0.
REQ-034 Owner 0 with done=1 and req[0]=0 in the same cycle, req=4'b0000 otherwise -> single release, IDLE, ptr=1; then req=4'b0011 -> grant to requester 1.
